// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, funct codes, ALU codes and the control bundle.
// DECODE_ILLEGAL_TRAP_EN adds an illegal-encoding flag to the control bundle.
package decode_pkg;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src2;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       is_branch;
    logic       reads_rt;   // rt is a source operand (hazard check)
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;
endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder: instr -> control bundle, register addresses, extended immediate.
// DECODE_ILLEGAL_TRAP_EN: also flags unknown opcode/funct.
module decode_comb
  import decode_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int IMM_SIGN_EXT = 1
) (
  input  logic [31:0]           instr,
  output ctrl_t                 ctrl,
  output logic [DATA_W-1:0]     imm,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] wr_addr
);
  logic [5:0] op, fn;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign fn           = instr[5:0];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign unused_shamt = ^instr[10:6];
  assign wr_addr      = (op == OP_RTYPE) ? instr[15:11] : instr[20:16];
  assign imm = (IMM_SIGN_EXT != 0) ? {{(DATA_W-16){instr[15]}}, instr[15:0]}
                                   : {{(DATA_W-16){1'b0}}, instr[15:0]};

  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.reads_rt = 1'b1;
        case (fn)
          FN_ADD: begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; end
          FN_SLT: begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_SLT; end
`ifdef DECODE_ILLEGAL_TRAP_EN
          default: ctrl.illegal = 1'b1;
`else
          default: ;
`endif
        endcase
      end
      OP_LW:   begin ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_src2 = 1'b1; end
      OP_SW:   begin ctrl.mem_write = 1'b1; ctrl.alu_src2 = 1'b1; ctrl.reads_rt = 1'b1; end
      OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src2 = 1'b1; end
      OP_BEQ:  begin ctrl.is_branch = 1'b1; ctrl.alu_op = ALU_SUB; ctrl.reads_rt = 1'b1; end
`ifdef DECODE_ILLEGAL_TRAP_EN
      default: ctrl.illegal = 1'b1;
`else
      default: ;
`endif
    endcase
    // r0 is hardwired zero: never write it
    if (wr_addr == '0) ctrl.reg_write = 1'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// Decode stage with ID/EX register, load-use interlock, EX flush and saturating stall counter.
// DECODE_ILLEGAL_TRAP_EN: adds out_illegal and locks intake while an illegal instruction sits in ID/EX.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter int IMM_SIGN_EXT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_W-1:0]     in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_pc,
  output logic [REG_ADDR_W-1:0] out_rs,
  output logic [REG_ADDR_W-1:0] out_rt,
  output logic [REG_ADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0]     out_imm,
  output logic [2:0]            out_alu_op,
  output logic                  out_alu_src2,
  output logic                  out_reg_write,
  output logic                  out_reg_dst,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_mem_to_reg,
  output logic                  out_is_branch,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                  out_illegal,
`endif
  output logic [CNT_W-1:0]      stall_count
);
  ctrl_t                 dec;
  logic [DATA_W-1:0]     dec_imm;
  logic [REG_ADDR_W-1:0] dec_rs, dec_rt, dec_wr;
  logic                  load_en, hazard, lock, fire;

  decode_comb #(.DATA_W(DATA_W), .IMM_SIGN_EXT(IMM_SIGN_EXT)) u_dec (
    .instr(in_instr), .ctrl(dec), .imm(dec_imm),
    .rs(dec_rs), .rt(dec_rt), .wr_addr(dec_wr)
  );

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign lock = out_valid & out_illegal;
`else
  assign lock = 1'b0;
`endif

  // A locked illegal instruction stays parked in ID/EX until flushed
  assign load_en  = (!out_valid || out_ready) && !lock;
  assign hazard   = out_valid && out_mem_read && (out_wr_addr != '0) && in_valid &&
                    ((dec_rs == out_wr_addr) || (dec.reads_rt && (dec_rt == out_wr_addr)));
  assign in_ready = flush || (load_en && !hazard);
  assign fire     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_rs         <= '0;
      out_rt         <= '0;
      out_wr_addr    <= '0;
      out_imm        <= '0;
      out_alu_op     <= '0;
      out_alu_src2   <= 1'b0;
      out_reg_write  <= 1'b0;
      out_reg_dst    <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_is_branch  <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      out_illegal    <= 1'b0;
`endif
      stall_count    <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      out_illegal    <= 1'b0;
`endif
    end else if (load_en) begin
      out_valid <= fire;
      if (fire) begin
        out_pc         <= in_pc;
        out_rs         <= dec_rs;
        out_rt         <= dec_rt;
        out_wr_addr    <= dec_wr;
        out_imm        <= dec_imm;
        out_alu_op     <= dec.alu_op;
        out_alu_src2   <= dec.alu_src2;
        out_reg_write  <= dec.reg_write;
        out_reg_dst    <= dec.reg_dst;
        out_mem_read   <= dec.mem_read;
        out_mem_write  <= dec.mem_write;
        out_mem_to_reg <= dec.mem_to_reg;
        out_is_branch  <= dec.is_branch;
`ifdef DECODE_ILLEGAL_TRAP_EN
        out_illegal    <= dec.illegal;
`endif
      end
      // hazard implies the load is leaving this cycle, so a bubble goes in
      if (hazard && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: scoreboard of expected ID/EX contents plus handshake/counter checks.
module tb_decode_stage;
  logic        clk = 1'b0, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs, out_rt, out_wr_addr;
  logic [2:0]  out_alu_op;
  logic        out_alu_src2, out_reg_write, out_reg_dst, out_mem_read, out_mem_write, out_mem_to_reg, out_is_branch;
  logic [15:0] stall_count;
  logic        z_in_ready, z_out_valid;
  logic [31:0] z_out_pc, z_out_imm;
  logic [4:0]  z_out_rs, z_out_rt, z_out_wr_addr;
  logic [2:0]  z_out_alu_op;
  logic        z_alu_src2, z_reg_write, z_reg_dst, z_mem_read, z_mem_write, z_mem_to_reg, z_is_branch;
  logic [1:0]  z_stall_count;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        out_illegal, z_out_illegal;
`endif

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt), .out_wr_addr(out_wr_addr),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_alu_src2(out_alu_src2),
    .out_reg_write(out_reg_write), .out_reg_dst(out_reg_dst), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg), .out_is_branch(out_is_branch),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .out_illegal(out_illegal),
`endif
    .stall_count(stall_count)
  );

  // Zero-extending, narrow-counter instance fed with the same stimulus
  decode_stage #(.DATA_W(32), .CNT_W(2), .IMM_SIGN_EXT(0)) dut_z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_pc(z_out_pc), .out_rs(z_out_rs), .out_rt(z_out_rt), .out_wr_addr(z_out_wr_addr),
    .out_imm(z_out_imm), .out_alu_op(z_out_alu_op), .out_alu_src2(z_alu_src2),
    .out_reg_write(z_reg_write), .out_reg_dst(z_reg_dst), .out_mem_read(z_mem_read),
    .out_mem_write(z_mem_write), .out_mem_to_reg(z_mem_to_reg), .out_is_branch(z_is_branch),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .out_illegal(z_out_illegal),
`endif
    .stall_count(z_stall_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs, rt, wr;
    logic [31:0] imm;
    logic [2:0]  alu;
    logic        src2, rw, rdst, mr, mw, m2r, br, ill;
  } exp_t;

  int   n_chk = 0, n_fail = 0;
  exp_t sb[$];

  localparam logic [31:0] I_ADD   = 32'h00221820; // add  $3,$1,$2
  localparam logic [31:0] I_ADDI  = 32'h20640005; // addi $4,$3,5
  localparam logic [31:0] I_LW    = 32'h8C250000; // lw   $5,0($1)
  localparam logic [31:0] I_DEP   = 32'h00A23020; // add  $6,$5,$2
  localparam logic [31:0] I_INDEP = 32'h00E23020; // add  $6,$7,$2
  localparam logic [31:0] I_ADDI0 = 32'h20200001; // addi $0,$1,1
  localparam logic [31:0] I_IMMFF = 32'h2064FFFF; // addi $4,$3,-1
  localparam logic [31:0] I_BAD   = 32'hFC000000; // op 3Fh

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op, fn;
    e = '0; op = i[31:26]; fn = i[5:0];
    e.pc = pc; e.rs = i[25:21]; e.rt = i[20:16];
    e.wr  = (op == 6'h00) ? i[15:11] : i[20:16];
    e.imm = {{16{i[15]}}, i[15:0]};
    case (op)
      6'h00: if (fn == 6'h20) {e.rw, e.rdst} = 2'b11;
             else if (fn == 6'h2A) begin {e.rw, e.rdst} = 2'b11; e.alu = 3'b100; end
             else e.ill = 1'b1;
      6'h23: {e.mr, e.m2r, e.src2} = 3'b111;
      6'h2B: {e.mw, e.src2} = 2'b11;
      6'h08: {e.rw, e.src2} = 2'b11;
      6'h04: begin e.br = 1'b1; e.alu = 3'b110; end
      default: e.ill = 1'b1;
    endcase
    if (e.wr == 5'd0) e.rw = 1'b0;
`ifndef DECODE_ILLEGAL_TRAP_EN
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.pc = out_pc; a.rs = out_rs; a.rt = out_rt; a.wr = out_wr_addr; a.imm = out_imm;
    a.alu = out_alu_op; a.src2 = out_alu_src2; a.rw = out_reg_write; a.rdst = out_reg_dst;
    a.mr = out_mem_read; a.mw = out_mem_write; a.m2r = out_mem_to_reg; a.br = out_is_branch;
`ifdef DECODE_ILLEGAL_TRAP_EN
    a.ill = out_illegal;
`else
    a.ill = 1'b0;
`endif
    return a;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (pop on out fire, push on in fire), then return #1 after posedge
  task automatic cyc(output bit fired);
    @(negedge clk);
    if (flush && out_valid) begin
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $error("FAIL sb_extra: observed output pc %0h expected no output", out_pc);
      end else chk("sb_out", actual(), sb.pop_front());
    end
    fired = in_valid && in_ready && !flush;
    if (fired) sb.push_back(model(in_instr, in_pc));
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, output int waits);
    bit f;
    in_valid = 1'b1; in_instr = instr; in_pc = pc; waits = 0;
    do begin
      cyc(f);
      if (!f) waits++;
    end while (!f && waits < 10);
    if (!f) begin n_chk++; n_fail++; $error("FAIL offer_timeout: observed no accept expected accept pc %0h", pc); end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    in_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) cyc(f);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int   w;
    bit   f;
    exp_t snap;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_fields", actual(), '0);
    rst = 1'b0; #1;
    chk("rel_in_ready", in_ready, 1);

    // streaming, full throughput
    offer(I_ADD,  32'h100, w); chk("stream_w0", w, 0);
    offer(I_ADDI, 32'h104, w); chk("stream_w1", w, 0);
    chk("addi_imm", out_imm, 32'h5);
    drain();

    // load-use: one bubble; unrelated reader: none
    offer(I_LW,  32'h200, w);
    offer(I_DEP, 32'h204, w); chk("dep_waits", w, 1);
    chk("dep_stall", stall_count, 1);
    drain();
    offer(I_LW,    32'h208, w);
    offer(I_INDEP, 32'h20C, w); chk("indep_waits", w, 0);
    drain();
    chk("indep_stall", stall_count, 1);

    // hold lw with dependent waiting: no bubble counted while held
    offer(I_LW, 32'h300, w);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_DEP; in_pc = 32'h304;
    snap = actual();
    repeat (3) begin
      cyc(f);
      chk("hold_stable", actual(), snap);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stall", stall_count, 1);
    end
    out_ready = 1'b1;
    offer(I_DEP, 32'h304, w); chk("release_waits", w, 1);
    chk("release_stall", stall_count, 2);
    drain();

    // flush kills ID/EX and drops the incoming instruction
    offer(I_ADD, 32'h400, w);
    flush = 1'b1; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h404; #1;
    chk("flush_in_ready", in_ready, 1);
    cyc(f);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sb", sb.size(), 0);
    chk("flush_stall", stall_count, 2);
    offer(I_ADDI0, 32'h408, w);
    chk("r0_reg_write", out_reg_write, 0);
    drain();

    // repeated hazards: wide counter counts, 2-bit counter saturates
    for (int k = 0; k < 4; k++) begin
      offer(I_LW,  32'h480 + 32'(k * 8), w);
      offer(I_DEP, 32'h484 + 32'(k * 8), w); chk("loop_waits", w, 1);
      drain();
    end
    chk("stall_six", stall_count, 6);
    chk("stall_sat", z_stall_count, 2'b11);

    // immediate extension
    offer(I_IMMFF, 32'h500, w);
    chk("imm_sext", out_imm, 32'hFFFFFFFF);
    chk("imm_zext", z_out_imm, 32'h0000FFFF);
    drain();

    // unknown opcode
    offer(I_BAD, 32'h600, w);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("illegal_set", out_illegal, 1);
    chk("illegal_fields", actual(), sb.pop_front());
    in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h604;
    repeat (3) begin
      @(negedge clk);
      chk("lock_in_ready", in_ready, 0);
      chk("lock_illegal", out_illegal, 1);
    end
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b0;
    cyc(f);
    flush = 1'b0;
    chk("unlock_illegal", out_illegal, 0);
    chk("unlock_in_ready", in_ready, 1);
`else
    chk("nop_valid", out_valid, 1);
    drain();
`endif

    // async reset mid-transfer
    offer(I_ADD, 32'h700, w);
    #2 rst = 1'b1; #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_stall", stall_count, 0);
    chk("arst_z_stall", z_stall_count, 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0; #1;
    chk("arst_in_ready", in_ready, 1);
    offer(I_ADDI, 32'h800, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
